// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package ifetch_pkg;

  localparam logic [31:0] HALT_INSTR_DEF = 32'hffff_ffff;
  localparam logic [31:0] PC_INC         = 32'd4;

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } fetch_state_e;

  // Instruction presented to decode together with its byte PC
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_pkt_t;

endpackage

// File: rtl/ifetch_ctrl_if.sv
// Bundle of ROM, decode, redirect and debug signals around the fetch sequencer.
interface ifetch_ctrl_if #(
  parameter int unsigned ADDR_W = 5
);

  logic [ADDR_W-1:0] rom_addr;
  logic [31:0]       rom_instr;
  logic              if_valid;
  logic              if_ready;
  logic [31:0]       if_pc;
  logic [31:0]       if_instr;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              stall;
  logic              halted;
  logic              fault;
  logic              dbg_req;
  logic [ADDR_W-1:0] dbg_addr;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [31:0]       dbg_rdata;

  modport master (
    output rom_addr, if_valid, if_pc, if_instr, halted, fault,
           dbg_gnt, dbg_rvalid, dbg_rdata,
    input  rom_instr, if_ready, redirect_valid, redirect_pc, stall,
           dbg_req, dbg_addr
  );

  modport slave (
    input  rom_addr, if_valid, if_pc, if_instr, halted, fault,
           dbg_gnt, dbg_rvalid, dbg_rdata,
    output rom_instr, if_ready, redirect_valid, redirect_pc, stall,
           dbg_req, dbg_addr
  );

endinterface

// File: rtl/rom_port_arb.sv
// Two-requester arbiter for the single ROM read port: fetch normally wins,
// debug gets idle cycles and preempts fetch after MAXWAIT cycles of waiting.
module rom_port_arb #(
  parameter int unsigned MAXWAIT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic fetch_want,
  input  logic dbg_req,
  output logic fetch_go,
  output logic dbg_gnt,
  output logic sel_dbg
);

  localparam int unsigned CNT_W = (MAXWAIT < 1) ? 1 : $clog2(MAXWAIT + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             starved;

  assign starved = (wait_cnt >= CNT_W'(MAXWAIT));

  always_comb begin
    dbg_gnt  = !rst && dbg_req && (!fetch_want || starved);
    fetch_go = !rst && fetch_want && !dbg_gnt;
    sel_dbg  = dbg_gnt;
  end

  // Counts cycles a debug request has been denied; never passes MAXWAIT
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (dbg_gnt) begin
      wait_cnt <= '0;
    end else if (dbg_req && !starved) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the ROM address, presents
// instructions through a registered valid/ready stage and detects halt/fault.
module ifetch_ctrl
  import ifetch_pkg::*;
#(
  parameter int unsigned ADDR_W      = 5,
  parameter logic [31:0] RESET_PC    = 32'h0,
  parameter logic [31:0] HALT_INSTR  = HALT_INSTR_DEF,
  parameter int unsigned DBG_MAXWAIT = 2
) (
  input  logic          clk,
  input  logic          rst,
  ifetch_ctrl_if.master bus
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  fetch_pkt_t   out_q, out_d;
  logic         valid_q, valid_d;
  logic         halted_q, halted_d;
  logic         fault_q, fault_d;
  logic         rvalid_q, rvalid_d;
  logic [31:0]  rdata_q, rdata_d;

  logic fetch_want;
  logic fetch_go;
  logic dbg_gnt;
  logic sel_dbg;
  logic pc_fault;

  assign pc_fault   = (pc_q[1:0] != 2'b00) || (pc_q[31:ADDR_W+2] != '0);
  assign fetch_want = (state_q == FETCH) && !bus.stall && !bus.redirect_valid &&
                      (!valid_q || bus.if_ready);

  rom_port_arb #(
    .MAXWAIT (DBG_MAXWAIT)
  ) u_arb (
    .clk        (clk),
    .rst        (rst),
    .fetch_want (fetch_want),
    .dbg_req    (bus.dbg_req),
    .fetch_go   (fetch_go),
    .dbg_gnt    (dbg_gnt),
    .sel_dbg    (sel_dbg)
  );

  // ROM address mux; reset shows the reset PC's word
  always_comb begin
    if (rst) begin
      bus.rom_addr = RESET_PC[ADDR_W+1:2];
    end else if (sel_dbg) begin
      bus.rom_addr = bus.dbg_addr;
    end else begin
      bus.rom_addr = pc_q[ADDR_W+1:2];
    end
  end

  // Next-state and next-output logic; redirect outranks everything but reset
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    out_d    = out_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    fault_d  = fault_q;
    rvalid_d = dbg_gnt;
    rdata_d  = dbg_gnt ? bus.rom_instr : rdata_q;

    if (bus.redirect_valid) begin
      state_d  = FETCH;
      pc_d     = bus.redirect_pc;
      valid_d  = 1'b0;
      halted_d = 1'b0;
      fault_d  = 1'b0;
    end else if (fetch_go) begin
      valid_d = 1'b0;
      if (pc_fault) begin
        state_d  = HALT;
        halted_d = 1'b1;
        fault_d  = 1'b1;
      end else if (bus.rom_instr == HALT_INSTR) begin
        state_d  = HALT;
        halted_d = 1'b1;
      end else begin
        valid_d = 1'b1;
        out_d   = '{pc: pc_q, instr: bus.rom_instr};
        pc_d    = pc_q + PC_INC;
      end
    end else if (valid_q && bus.if_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      out_q    <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      fault_q  <= fault_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign bus.if_valid   = valid_q;
  assign bus.if_pc      = out_q.pc;
  assign bus.if_instr   = out_q.instr;
  assign bus.halted     = halted_q;
  assign bus.fault      = fault_q;
  assign bus.dbg_gnt    = dbg_gnt;
  assign bus.dbg_rvalid = rvalid_q;
  assign bus.dbg_rdata  = rdata_q;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed vector bench for ifetch_ctrl with a 32-word combinational ROM model.
module tb_ifetch_ctrl;

  localparam logic [31:0] W0 = 32'h0060_0513;
  localparam logic [31:0] W1 = 32'h00c0_00ef;
  localparam logic [31:0] W2 = 32'h00a0_2023;
  localparam logic [31:0] W3 = 32'hffff_ffff;
  localparam logic [31:0] W4 = 32'hff81_0113;
  localparam logic [31:0] W5 = 32'h0011_2223;
  localparam logic [31:0] W6 = 32'h00a1_2023;
  localparam logic [31:0] W7 = 32'ha000_0007;
  localparam logic [31:0] W8 = 32'ha000_0008;
  localparam logic [31:0] W9 = 32'ha000_0009;
  localparam int NV = 37;

  typedef struct {
    logic        rst, rdy, rv;
    logic [31:0] rpc;
    logic        stl, dreq;
    logic [4:0]  da;
    logic [4:0]  ea;
    logic        eg, ev;
    logic [31:0] epc, ei;
    logic        eh, ef, erv;
    logic [31:0] erd;
  } vec_t;

  logic clk;
  logic rst;
  logic [31:0] rom [32];
  int tests;
  int fails;
  vec_t vecs [NV];

  ifetch_ctrl_if #(.ADDR_W(5)) bus ();

  ifetch_ctrl #(
    .ADDR_W      (5),
    .RESET_PC    (32'h0),
    .HALT_INSTR  (32'hffff_ffff),
    .DBG_MAXWAIT (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.rom_instr = rom[bus.rom_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  function automatic vec_t mk(input logic r, rdy, rv, input logic [31:0] rpc,
                              input logic stl, dreq, input logic [4:0] da,
                              input logic [4:0] ea, input logic eg, ev,
                              input logic [31:0] epc, ei,
                              input logic eh, ef, erv, input logic [31:0] erd);
    vec_t v;
    v.rst = r; v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.stl = stl; v.dreq = dreq;
    v.da = da; v.ea = ea; v.eg = eg; v.ev = ev; v.epc = epc; v.ei = ei;
    v.eh = eh; v.ef = ef; v.erv = erv; v.erd = erd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  task automatic apply_vec(input int idx, input vec_t v);
    @(negedge clk);
    rst                = v.rst;
    bus.if_ready       = v.rdy;
    bus.redirect_valid = v.rv;
    bus.redirect_pc    = v.rpc;
    bus.stall          = v.stl;
    bus.dbg_req        = v.dreq;
    bus.dbg_addr       = v.da;
    #1;
    tests++;
    if (bus.rom_addr !== v.ea || bus.dbg_gnt !== v.eg) begin
      fails++;
      $display("FAIL vec%0d comb: rom_addr=%0d dbg_gnt=%0b, required rom_addr=%0d dbg_gnt=%0b",
               idx, bus.rom_addr, bus.dbg_gnt, v.ea, v.eg);
    end
    @(posedge clk);
    #1;
    tests++;
    if (bus.if_valid !== v.ev || bus.if_pc !== v.epc || bus.if_instr !== v.ei ||
        bus.halted !== v.eh || bus.fault !== v.ef || bus.dbg_rvalid !== v.erv ||
        bus.dbg_rdata !== v.erd) begin
      fails++;
      $display("FAIL vec%0d regs: got v=%0b pc=%h instr=%h halted=%0b fault=%0b rvalid=%0b rdata=%h, required v=%0b pc=%h instr=%h halted=%0b fault=%0b rvalid=%0b rdata=%h",
               idx, bus.if_valid, bus.if_pc, bus.if_instr, bus.halted, bus.fault,
               bus.dbg_rvalid, bus.dbg_rdata, v.ev, v.epc, v.ei, v.eh, v.ef, v.erv, v.erd);
    end
  endtask

  initial begin
    int lat;
    tests = 0;
    fails = 0;
    for (int i = 0; i < 32; i++) rom[i] = 32'ha000_0000 + 32'(i);
    rom[0] = W0; rom[1] = W1; rom[2] = W2; rom[3] = W3;
    rom[4] = W4; rom[5] = W5; rom[6] = W6;

    rst = 1'b1;
    bus.if_ready = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
    bus.stall = 1'b0; bus.dbg_req = 1'b0; bus.dbg_addr = '0;
    repeat (2) @(posedge clk);

    //          rst rdy rv rpc      stl dreq da  ea eg  ev epc      ei  eh ef erv erd
    vecs[0]  = mk(1, 1, 0, 32'h0,  0, 0, 0,  0, 0,  0, 32'h0,  32'h0, 0, 0, 0, 32'h0);
    vecs[1]  = mk(0, 1, 0, 32'h0,  0, 0, 0,  0, 0,  1, 32'h0,  W0, 0, 0, 0, 32'h0);
    vecs[2]  = mk(0, 1, 0, 32'h0,  0, 0, 0,  1, 0,  1, 32'h4,  W1, 0, 0, 0, 32'h0);
    vecs[3]  = mk(0, 0, 0, 32'h0,  0, 0, 0,  2, 0,  1, 32'h4,  W1, 0, 0, 0, 32'h0);
    vecs[4]  = mk(0, 0, 0, 32'h0,  0, 0, 0,  2, 0,  1, 32'h4,  W1, 0, 0, 0, 32'h0);
    vecs[5]  = mk(0, 0, 0, 32'h0,  0, 0, 0,  2, 0,  1, 32'h4,  W1, 0, 0, 0, 32'h0);
    vecs[6]  = mk(0, 1, 0, 32'h0,  0, 0, 0,  2, 0,  1, 32'h8,  W2, 0, 0, 0, 32'h0);
    vecs[7]  = mk(0, 1, 0, 32'h0,  0, 0, 0,  3, 0,  0, 32'h8,  W2, 1, 0, 0, 32'h0);
    vecs[8]  = mk(0, 1, 0, 32'h0,  0, 0, 0,  3, 0,  0, 32'h8,  W2, 1, 0, 0, 32'h0);
    vecs[9]  = mk(0, 1, 1, 32'h14, 0, 0, 0,  3, 0,  0, 32'h8,  W2, 0, 0, 0, 32'h0);
    vecs[10] = mk(0, 1, 0, 32'h0,  0, 0, 0,  5, 0,  1, 32'h14, W5, 0, 0, 0, 32'h0);
    vecs[11] = mk(0, 1, 0, 32'h0,  0, 0, 0,  6, 0,  1, 32'h18, W6, 0, 0, 0, 32'h0);
    vecs[12] = mk(0, 1, 1, 32'h10, 0, 0, 0,  7, 0,  0, 32'h18, W6, 0, 0, 0, 32'h0);
    vecs[13] = mk(0, 1, 0, 32'h0,  0, 0, 0,  4, 0,  1, 32'h10, W4, 0, 0, 0, 32'h0);
    vecs[14] = mk(0, 1, 0, 32'h0,  0, 0, 0,  5, 0,  1, 32'h14, W5, 0, 0, 0, 32'h0);
    vecs[15] = mk(0, 1, 0, 32'h0,  0, 1, 6,  6, 0,  1, 32'h18, W6, 0, 0, 0, 32'h0);
    vecs[16] = mk(0, 1, 0, 32'h0,  0, 1, 6,  7, 0,  1, 32'h1c, W7, 0, 0, 0, 32'h0);
    vecs[17] = mk(0, 1, 0, 32'h0,  0, 1, 6,  6, 1,  0, 32'h1c, W7, 0, 0, 1, W6);
    vecs[18] = mk(0, 1, 0, 32'h0,  0, 0, 0,  8, 0,  1, 32'h20, W8, 0, 0, 0, W6);
    vecs[19] = mk(0, 1, 0, 32'h0,  1, 1, 2,  2, 1,  0, 32'h20, W8, 0, 0, 1, W2);
    vecs[20] = mk(0, 1, 0, 32'h0,  0, 0, 0,  9, 0,  1, 32'h24, W9, 0, 0, 0, W2);
    vecs[21] = mk(0, 1, 1, 32'h82, 0, 0, 0, 10, 0,  0, 32'h24, W9, 0, 0, 0, W2);
    vecs[22] = mk(0, 1, 0, 32'h0,  0, 0, 0,  0, 0,  0, 32'h24, W9, 1, 1, 0, W2);
    vecs[23] = mk(0, 1, 1, 32'h80, 0, 0, 0,  0, 0,  0, 32'h24, W9, 0, 0, 0, W2);
    vecs[24] = mk(0, 1, 0, 32'h0,  0, 0, 0,  0, 0,  0, 32'h24, W9, 1, 1, 0, W2);
    vecs[25] = mk(0, 1, 0, 32'h0,  0, 1, 4,  4, 1,  0, 32'h24, W9, 1, 1, 1, W4);
    vecs[26] = mk(0, 1, 0, 32'h0,  0, 0, 0,  0, 0,  0, 32'h24, W9, 1, 1, 0, W4);
    vecs[27] = mk(0, 1, 1, 32'h0,  0, 0, 0,  0, 0,  0, 32'h24, W9, 0, 0, 0, W4);
    vecs[28] = mk(0, 1, 0, 32'h0,  0, 0, 0,  0, 0,  1, 32'h0,  W0, 0, 0, 0, W4);
    vecs[29] = mk(0, 1, 0, 32'h0,  0, 1, 5,  1, 0,  1, 32'h4,  W1, 0, 0, 0, W4);
    vecs[30] = mk(1, 1, 1, 32'h40, 0, 1, 5,  0, 0,  0, 32'h0,  32'h0, 0, 0, 0, 32'h0);
    vecs[31] = mk(0, 1, 0, 32'h0,  0, 1, 5,  0, 0,  1, 32'h0,  W0, 0, 0, 0, 32'h0);
    vecs[32] = mk(0, 1, 0, 32'h0,  0, 1, 5,  1, 0,  1, 32'h4,  W1, 0, 0, 0, 32'h0);
    vecs[33] = mk(0, 1, 0, 32'h0,  0, 1, 5,  5, 1,  0, 32'h4,  W1, 0, 0, 1, W5);
    vecs[34] = mk(0, 0, 0, 32'h0,  0, 0, 0,  2, 0,  1, 32'h8,  W2, 0, 0, 0, W5);
    vecs[35] = mk(0, 0, 0, 32'h0,  0, 0, 0,  3, 0,  1, 32'h8,  W2, 0, 0, 0, W5);
    vecs[36] = mk(0, 1, 0, 32'h0,  0, 0, 0,  3, 0,  0, 32'h8,  W2, 1, 0, 0, W5);

    for (int i = 0; i < NV; i++) apply_vec(i, vecs[i]);

    // Leave HALT, stream, and measure debug latency for a read of the halt word
    @(negedge clk);
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h20; bus.if_ready = 1'b1;
    @(posedge clk); #1;
    chk("redir_halted_clear", 32'(bus.halted), 32'h0);
    @(negedge clk);
    bus.redirect_valid = 1'b0; bus.dbg_req = 1'b1; bus.dbg_addr = 5'd3;
    lat = 0;
    for (int c = 1; c <= 6; c++) begin
      #1;
      if (bus.dbg_gnt === 1'b1) begin
        lat = c;
        break;
      end
      @(negedge clk);
    end
    chk("dbg_latency", 32'(lat), 32'd3);
    @(posedge clk); #1;
    bus.dbg_req = 1'b0;
    chk("dbg_rvalid_seq", 32'(bus.dbg_rvalid), 32'h1);
    chk("dbg_rdata_seq", bus.dbg_rdata, W3);
    chk("dbg_no_halt", 32'(bus.halted), 32'h0);
    chk("dbg_skip_valid", 32'(bus.if_valid), 32'h0);
    chk("dbg_skip_pc", bus.if_pc, 32'h24);
    @(posedge clk); #1;
    chk("dbg_rvalid_drop", 32'(bus.dbg_rvalid), 32'h0);
    chk("dbg_rdata_hold", bus.dbg_rdata, W3);
    chk("resume_pc", bus.if_pc, 32'h28);
    chk("resume_valid", 32'(bus.if_valid), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
